// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
//   Parametrised register file with NUM_READ combinational read ports, one
//   writeback port and a per-register busy scoreboard for in-flight writes.
//   After reset a clear engine zeroes the whole array, one entry per clock.
//   While it runs, ready stays low, reads return 0, and writes and reserves
//   are ignored.
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-high reset; restarts the clear engine
//   read_address    packed read addresses, port i at [i*AW +: AW]
//   read_data       packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   read_busy       port i addresses a register with a pending write
//   write_address   writeback destination
//   write_data      writeback value
//   write_enable    commit write this cycle
//   reserve_address destination being issued
//   reserve_enable  mark reserve_address busy
//   ready           clear engine finished; array valid
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   Defined   - a write in the current cycle is forwarded to every read port
//               whose address matches it. Busy is then 1 only if the same
//               register is reserved in this cycle.
//   Undefined - reads return stored contents only.

module register_file_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_READ*$clog2(NUM_REGS)-1:0]       read_address,
  output logic [NUM_READ*DATA_WIDTH-1:0]             read_data,
  output logic [NUM_READ-1:0]                        read_busy,
  input  logic [$clog2(NUM_REGS)-1:0]                write_address,
  input  logic [DATA_WIDTH-1:0]                      write_data,
  input  logic                                       write_enable,
  input  logic [$clog2(NUM_REGS)-1:0]                reserve_address,
  input  logic                                       reserve_enable,
  output logic                                       ready
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t                  state, state_next;
  logic [AW-1:0]           clear_ptr;
  logic [NUM_REGS-1:0]     busy, busy_next;
  logic [DATA_WIDTH-1:0]   file [NUM_REGS];
  logic [AW-1:0]           rd_addr [NUM_READ];
  logic                    write_fire, reserve_fire;

  // Register 0 is hardwired: it is never stored and never marked busy.
  always_comb begin
    ready        = (state == S_RUN);
    write_fire   = ready && write_enable   && (write_address   != '0);
    reserve_fire = ready && reserve_enable && (reserve_address != '0);
  end

  always_comb begin
    state_next = state;
    if ((state == S_CLEAR) && (clear_ptr == AW'(NUM_REGS - 1)))
      state_next = S_RUN;
  end

  // The reserve is applied after the write, so a write and a reserve to the
  // same register on one edge leave it busy (back-to-back WAW).
  always_comb begin
    busy_next = busy;
    if (write_fire)
      busy_next[write_address] = 1'b0;
    if (reserve_fire)
      busy_next[reserve_address] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CLEAR;
      clear_ptr <= '0;
      busy      <= '0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      if (state == S_CLEAR)
        clear_ptr <= clear_ptr + 1'b1;
    end
  end

  // The storage array has no reset; the clear engine zero-fills it instead.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      file[clear_ptr] <= '0;
    else if (write_fire)
      file[write_address] <= write_data;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_READ; i++)
      rd_addr[i] = read_address[i*AW +: AW];
  end

  always_comb begin
    read_data = '0;
    read_busy = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      if (ready && (rd_addr[i] != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (write_enable && (write_address == rd_addr[i])) begin
          read_data[i*DATA_WIDTH +: DATA_WIDTH] = write_data;
          read_busy[i] = reserve_enable && (reserve_address == rd_addr[i]);
        end else begin
          read_data[i*DATA_WIDTH +: DATA_WIDTH] = file[rd_addr[i]];
          read_busy[i] = busy[rd_addr[i]];
        end
`else
        read_data[i*DATA_WIDTH +: DATA_WIDTH] = file[rd_addr[i]];
        read_busy[i] = busy[rd_addr[i]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Testbench for register_file_scoreboard (default parameters: 32 x 32-bit,
// two read ports). It uses a behavioural reference model of the register
// contents, the busy bits and the clear-sequence progress.

module tb_register_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  read_address;
  logic [63:0] read_data;
  logic [1:0]  read_busy;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        write_enable;
  logic [4:0]  reserve_address;
  logic        reserve_enable;
  logic        ready;

  logic [4:0]  ra0, ra1;

  int tests  = 0;
  int failed = 0;

  // reference model
  logic [31:0] m_data [32];
  logic        m_busy [32];
  logic        m_ready;
  int          m_clear_cnt;

  always #5 clk = ~clk;

  assign read_address = {ra1, ra0};

  register_file_scoreboard #(
    .DATA_WIDTH (32),
    .NUM_REGS   (32),
    .NUM_READ   (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .read_address    (read_address),
    .read_data       (read_data),
    .read_busy       (read_busy),
    .write_address   (write_address),
    .write_data      (write_data),
    .write_enable    (write_enable),
    .reserve_address (reserve_address),
    .reserve_enable  (reserve_enable),
    .ready           (ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_ready     = 1'b0;
    m_clear_cnt = 0;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!m_ready || a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (write_enable && write_address == a) return write_data;
`endif
    return m_data[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!m_ready || a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (write_enable && write_address == a)
      return reserve_enable && reserve_address == a;
`endif
    return m_busy[a];
  endfunction

  // Model of one rising edge: the clear sequence needs 32 edges; after it
  // the write lands first and the reserve is applied on top of it.
  task automatic model_edge();
    if (!m_ready) begin
      m_clear_cnt++;
      if (m_clear_cnt == 32) m_ready = 1'b1;
    end else begin
      if (write_enable && write_address != 5'd0) begin
        m_data[write_address] = write_data;
        m_busy[write_address] = 1'b0;
      end
      if (reserve_enable && reserve_address != 5'd0)
        m_busy[reserve_address] = 1'b1;
    end
  endtask

  task automatic chk_ports(input string tag);
    chk({tag, ".ready"}, ready, m_ready);
    chk({tag, ".d0"}, read_data[31:0],  exp_data(ra0));
    chk({tag, ".d1"}, read_data[63:32], exp_data(ra1));
    chk({tag, ".b0"}, read_busy[0], exp_busy(ra0));
    chk({tag, ".b1"}, read_busy[1], exp_busy(ra1));
  endtask

  task automatic set_in(input logic [4:0] a0, input logic [4:0] a1,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re, input logic [4:0] rsa);
    ra0 = a0; ra1 = a1;
    write_enable = we; write_address = wa; write_data = wd;
    reserve_enable = re; reserve_address = rsa;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick(input string tag);
    #1;
    chk_ports(tag);
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic idle_tick(input string tag);
    set_in(ra0, ra1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    tick(tag);
  endtask

  task automatic rand_in(input bit allow_zero);
    logic [4:0] a0, a1, wa, rsa;
    a0  = 5'($urandom_range(allow_zero ? 0 : 1, 31));
    a1  = 5'($urandom_range(allow_zero ? 0 : 1, 31));
    wa  = 5'($urandom_range(allow_zero ? 0 : 1, 31));
    rsa = 5'($urandom_range(allow_zero ? 0 : 1, 31));
    // Bias reads towards the write target so forwarding cases occur.
    if ($urandom_range(0, 3) == 0) a1 = wa;
    set_in(a0, a1, 1'($urandom_range(0, 1)), wa, $urandom,
           1'($urandom_range(0, 1)), rsa);
  endtask

  task automatic sweep_zero(input string tag);
    for (int k = 0; k < 16; k++) begin
      set_in(5'(2*k), 5'(2*k+1), 1'b0, 5'd0, '0, 1'b0, 5'd0);
      #1;
      chk({tag, ".d0"}, read_data[31:0], 32'h0);
      chk({tag, ".d1"}, read_data[63:32], 32'h0);
      chk({tag, ".busy"}, read_busy, 2'b00);
      tick(tag);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    set_in(5'd5, 5'd31, 1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5);
    #1;
    chk_ports("reset");
    chk("reset_ready", ready, 1'b0);
    @(negedge clk);

    // Clear sequence: writes are offered on every cycle and must be ignored.
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rand_in(1'b0);
      write_enable = 1'b1;
      #1;
      chk("clear_ready_low", ready, 1'b0);
      tick("clear");
    end
    #1;
    chk("clear_ready_high", ready, 1'b1);
    sweep_zero("after_clear");

    // Basic write/read
    set_in(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    tick("wr_x5");
    set_in(5'd5, 5'd5, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    #1;
    chk("x5_p0", read_data[31:0], 32'hDEADBEEF);
    chk("x5_p1", read_data[63:32], 32'hDEADBEEF);
    tick("rd_x5");
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    tick("wr_x0");
    idle_tick("rd_x0");
    #1;
    chk("x0_zero", read_data[31:0], 32'h0);

    // Scoreboard
    set_in(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd7);
    tick("rsv_x7");
    set_in(5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    #1;
    chk("x7_busy", read_busy[0], 1'b1);
    tick("rd_x7");
    set_in(5'd0, 5'd0, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0);
    tick("wr_x7");
    set_in(5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    #1;
    chk("x7_data", read_data[31:0], 32'h55);
    chk("x7_free", read_busy[0], 1'b0);
    tick("rd_x7b");
    set_in(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd0);
    tick("rsv_x0");
    idle_tick("rd_x0_busy");
    #1;
    chk("x0_not_busy", read_busy[0], 1'b0);

    // Simultaneous events
    set_in(5'd0, 5'd0, 1'b1, 5'd9, 32'hA, 1'b1, 5'd9);
    tick("wr_rsv_x9");
    set_in(5'd9, 5'd3, 1'b1, 5'd4, 32'h44, 1'b1, 5'd3);
    #1;
    chk("x9_data", read_data[31:0], 32'hA);
    chk("x9_busy", read_busy[0], 1'b1);
    tick("rsv3_wr4");
    set_in(5'd3, 5'd4, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    #1;
    chk("x3_busy", read_busy[0], 1'b1);
    chk("x4_data", read_data[63:32], 32'h44);
    tick("rd_3_4");

    // Forwarding case: port 1 reads x12 while it is written
    set_in(5'd0, 5'd12, 1'b1, 5'd12, 32'hCAFE, 1'b0, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x12_same_cycle", read_data[63:32], 32'hCAFE);
`else
    chk("x12_same_cycle", read_data[63:32], 32'h0);
`endif
    tick("wr_x12");
    set_in(5'd0, 5'd12, 1'b0, 5'd12, 32'hBEEF, 1'b0, 5'd0);
    #1;
    chk("x12_next", read_data[63:32], 32'hCAFE);
    chk("x12_no_fwd_we0", read_data[63:32], 32'hCAFE);
    tick("x12_we0");

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rand_in(1'b1);
      tick("rand");
    end

    // Reset mid-operation
    for (int r = 1; r < 32; r++) begin
      set_in(5'(r), 5'd0, 1'b1, 5'(r), 32'h100 + 32'(r), 1'b0, 5'd0);
      tick("fill");
    end
    set_in(5'd2, 5'd31, 1'b0, 5'd0, '0, 1'b1, 5'd2);
    tick("rsv_x2");
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_data", read_data, 64'h0);
    chk("midrst_busy", read_busy, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rand_in(1'b0);
      tick("reclear");
    end
    #1;
    chk("reclear_ready", ready, 1'b1);
    sweep_zero("after_reclear");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
